// File: rtl/counter_timer_ctrl_pkg.sv
// Shared types and helpers for the interval timer controller.
// State encoding and terminal/reload value decode.
package counter_timer_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Up-counting runs 0..period; down-counting runs period..0.
  function automatic logic [31:0] start_val(
    input logic        up,
    input logic [31:0] per
  );
    return up ? 32'd0 : per;
  endfunction

  function automatic logic [31:0] term_val(
    input logic        up,
    input logic [31:0] per
  );
    return up ? per : 32'd0;
  endfunction

endpackage

// File: rtl/counter_behavioral.sv
// Loadable up/down counter with enable.
// Sole counting datapath of the timer.
module counter_behavioral #(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         en,
  input  logic         count_up,
  input  logic         load,
  input  logic [n-1:0] set,
  output logic [n-1:0] count
);

  // Load has priority over stepping; en=0 freezes the value.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      count <= '0;
    end else if (en) begin
      if (load)
        count <= set;
      else if (count_up)
        count <= count + 1'b1;
      else
        count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/counter_timer_ctrl.sv
// Interval timer sequencer around counter_behavioral.
// One-shot or periodic, up or down, with hold/abort.
module counter_timer_ctrl
  import counter_timer_ctrl_pkg::*;
#(
  parameter int n = 4
) (
  input  logic         clk,
  input  logic         res_n,
  input  logic         start,
  input  logic         abort,
  input  logic         hold,
  input  logic         periodic,
  input  logic         count_up,
  input  logic [n-1:0] period,
  output logic         busy,
  output logic         tick,
  output logic         done,
  output logic [n-1:0] count
);

  state_t       state_q;
  state_t       state_d;
  logic [n-1:0] per_q;
  logic         per_mode_q;
  logic         up_q;

  logic         cnt_en;
  logic         cnt_load;
  logic [n-1:0] cnt_set;
  logic         take;
  logic         at_term;
  logic [31:0]  per_w;
  logic [31:0]  new_w;
  logic [31:0]  lat_w;
  logic [31:0]  term_w;

  assign per_w   = 32'(period);
  assign lat_w   = 32'(per_q);
  assign new_w   = start_val(count_up, per_w);
  assign term_w  = term_val(up_q, lat_w);
  assign at_term = (count == term_w[n-1:0]);
  assign take    = (state_q != RUN)
                 && start && !abort;

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n)
      state_q <= IDLE;
    else
      state_q <= state_d;
  end

  // Configuration is captured only when a start is accepted.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      per_q      <= '0;
      per_mode_q <= 1'b0;
      up_q       <= 1'b0;
    end else if (take) begin
      per_q      <= period;
      per_mode_q <= periodic;
      up_q       <= count_up;
    end
  end

  // Next state, tick and counter control.
  always_comb begin
    state_d  = state_q;
    cnt_en   = 1'b0;
    cnt_load = 1'b0;
    cnt_set  = '0;
    tick     = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (abort) begin
          state_d = IDLE;
        end else if (start) begin
          cnt_en   = 1'b1;
          cnt_load = 1'b1;
          cnt_set  = new_w[n-1:0];
          state_d  = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!hold) begin
          cnt_en = 1'b1;
          if (at_term) begin
            tick = 1'b1;
            if (per_mode_q) begin
              cnt_load = 1'b1;
              cnt_set  = up_q ? '0 : per_q;
            end else begin
              cnt_en  = 1'b0;
              state_d = DONE;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  counter_behavioral #(.n(n)) u_cnt (
    .clk      (clk),
    .res_n    (res_n),
    .en       (cnt_en),
    .count_up (up_q | cnt_load & count_up),
    .load     (cnt_load),
    .set      (cnt_set),
    .count    (count)
  );

endmodule

// File: tb/tb_counter_timer_ctrl.sv
// Directed self-checking bench for counter_timer_ctrl.
// Linear stimulus with hand-computed expectations.
module tb_counter_timer_ctrl;

  logic       clk = 1'b0;
  logic       res_n;
  logic       start;
  logic       abort;
  logic       hold;
  logic       periodic;
  logic       count_up;
  logic [3:0] period;
  logic       busy;
  logic       tick;
  logic       done;
  logic [3:0] count;

  int n_pass = 0;
  int n_total = 0;

  counter_timer_ctrl #(.n(4)) dut (
    .clk      (clk),
    .res_n    (res_n),
    .start    (start),
    .abort    (abort),
    .hold     (hold),
    .periodic (periodic),
    .count_up (count_up),
    .period   (period),
    .busy     (busy),
    .tick     (tick),
    .done     (done),
    .count    (count)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d",
                tag, got, exp);
  endtask

  task automatic chk_all(
    input string tag,
    input int    c,
    input int    t,
    input int    b,
    input int    d
  );
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".tick"},  32'(tick),  32'(t));
    chk({tag, ".busy"},  32'(busy),  32'(b));
    chk({tag, ".done"},  32'(done),  32'(d));
  endtask

  initial begin
    int e;
    res_n = 1'b0; start = 0; abort = 0; hold = 0;
    periodic = 0; count_up = 0; period = 0;
    #12;
    chk_all("reset", 0, 0, 0, 0);
    cyc();
    res_n = 1'b1;
    cyc();

    // 1: one-shot up, period 3
    period = 4'd3; count_up = 1; periodic = 0;
    start = 1;
    cyc();
    start = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk_all("t1.run", i, (i == 3) ? 1 : 0, 1, 0);
      cyc();
    end
    for (int i = 0; i < 10; i++) begin
      chk_all("t1.done", 3, 0, 0, 1);
      cyc();
    end

    // 2: periodic down, period 2, mid-run change
    period = 4'd2; count_up = 0; periodic = 1;
    start = 1;
    cyc();
    start = 0; #1;
    for (int i = 0; i < 9; i++) begin
      if (i == 3) begin period = 4'd9; #1; end
      e = 2 - (i % 3);
      chk_all("t2.seq", e, (e == 0) ? 1 : 0, 1, 0);
      cyc();
    end
    abort = 1;
    cyc();
    abort = 0; #1;
    chk_all("t2.abort", 2, 0, 0, 0);

    // 3: periodic down, period 5, hold at 3
    period = 4'd5; count_up = 0; periodic = 1;
    start = 1;
    cyc();
    start = 0; #1;
    chk("t3.c5", 32'(count), 32'd5);
    cyc();
    chk("t3.c4", 32'(count), 32'd4);
    cyc();
    hold = 1; #1;
    for (int i = 0; i < 4; i++) begin
      chk_all("t3.hold", 3, 0, 1, 0);
      cyc();
    end
    hold = 0; #1;
    chk_all("t3.rel", 3, 0, 1, 0);
    cyc();
    chk_all("t3.c2", 2, 0, 1, 0);
    cyc();
    chk_all("t3.c1", 1, 0, 1, 0);
    cyc();
    chk_all("t3.c0", 0, 1, 1, 0);
    cyc();
    chk_all("t3.reload", 5, 0, 1, 0);
    abort = 1;
    cyc();
    abort = 0; #1;

    // 4: start+abort in RUN, start in RUN, start in DONE
    period = 4'd6; count_up = 1; periodic = 1;
    start = 1;
    cyc();
    start = 0;
    cyc();
    cyc();
    chk("t4.pre", 32'(count), 32'd2);
    start = 1; abort = 1; #1;
    chk("t4.sa.tick", 32'(tick), 32'd0);
    cyc();
    start = 0; abort = 0; #1;
    chk_all("t4.sa", 2, 0, 0, 0);
    cyc();
    chk_all("t4.idle", 2, 0, 0, 0);
    period = 4'd4; count_up = 1; periodic = 0;
    start = 1;
    cyc();
    chk_all("t4.s0", 0, 0, 1, 0);
    period = 4'd1;
    cyc();
    start = 0; #1;
    chk_all("t4.s1", 1, 0, 1, 0);
    cyc();
    chk_all("t4.s2", 2, 0, 1, 0);
    cyc();
    chk_all("t4.s3", 3, 0, 1, 0);
    cyc();
    chk_all("t4.s4", 4, 1, 1, 0);
    cyc();
    chk_all("t4.done", 4, 0, 0, 1);
    period = 4'd2; count_up = 0; periodic = 0;
    start = 1;
    cyc();
    start = 0; #1;
    chk_all("t4.rst", 2, 0, 1, 0);
    cyc();
    chk_all("t4.rst1", 1, 0, 1, 0);
    abort = 1;
    cyc();
    abort = 0; #1;

    // 5: period 0 periodic; period 15 one-shot up
    period = 4'd0; count_up = 1; periodic = 1;
    start = 1;
    cyc();
    start = 0; #1;
    for (int i = 0; i < 4; i++) begin
      chk_all("t5.p0", 0, 1, 1, 0);
      cyc();
    end
    abort = 1; #1;
    chk("t5.abort.tick", 32'(tick), 32'd0);
    cyc();
    abort = 0;
    period = 4'd15; count_up = 1; periodic = 0;
    start = 1;
    cyc();
    start = 0; #1;
    for (int i = 0; i < 16; i++) begin
      chk_all("t5.p15", i, (i == 15) ? 1 : 0, 1, 0);
      cyc();
    end
    chk_all("t5.done", 15, 0, 0, 1);
    cyc();
    chk_all("t5.nowrap", 15, 0, 0, 1);

    // 6: async reset mid-run at count 7
    period = 4'd10; count_up = 1; periodic = 1;
    start = 1;
    cyc();
    start = 0;
    for (int i = 0; i < 7; i++) cyc();
    chk_all("t6.pre", 7, 0, 1, 0);
    #2;
    res_n = 1'b0;
    #1;
    chk_all("t6.async", 0, 0, 0, 0);
    #1;
    res_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_all("t6.idle", 0, 0, 0, 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
